isa16_mc_control: RTL and testbench

Multi-cycle control unit for the 16-bit ISA core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the register file, ALU, immediate sign-extender, PC and IR enables, and a single-port memory request/ready handshake. It also counts retired instructions and halts on HALT or on an illegal opcode.

---
 rtl/isa16_mc_control.sv | 193 +++++++++++++++++++
 tb/tb_isa16_mc_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa16_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : isa16_mc_control
//  Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit
//             ISA core, with HALT/illegal-opcode stop and retire counter.
//  Revision : 1.0 - initial release
// ============================================================================
module isa16_mc_control #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         instr,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [2:0]          alu_op,
    output logic                alu_src_imm,
    output logic                reg_write,
    output logic                wb_sel,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_addi = 4'd4;
    localparam logic [3:0] c_op_lw   = 4'd5;
    localparam logic [3:0] c_op_sw   = 4'd6;
    localparam logic [3:0] c_op_beq  = 4'd7;
    localparam logic [3:0] c_op_jmp  = 4'd8;
    localparam logic [3:0] c_op_halt = 4'd15;

    localparam logic [2:0] c_alu_sub = 3'd1;
    localparam logic [1:0] c_pc_rel  = 2'd1;
    localparam logic [1:0] c_pc_abs  = 2'd2;

    localparam logic [RETIRE_W-1:0] c_retire_one = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [2:0]          r_state;
    logic [3:0]          r_op_q;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_halted;
    logic                r_illegal;

    logic [3:0] w_op;
    logic       w_op_illegal;
    logic       w_unused;

    assign w_op         = instr[15:12];
    assign w_op_illegal = (w_op >= 4'd9) && (w_op != c_op_halt);
    // Operand fields are consumed by the datapath, not by the sequencer.
    assign w_unused     = ^instr[11:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_fetch;
            r_op_q    <= 4'd0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (instr_done) begin
                r_retired <= r_retired + c_retire_one;
            end
            case (r_state)
                c_st_fetch: begin
                    if (mem_ready) begin
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    r_op_q <= w_op;
                    if (w_op == c_op_halt) begin
                        r_state  <= c_st_halt;
                        r_halted <= 1'b1;
                    end else if (w_op_illegal) begin
                        r_state   <= c_st_halt;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    case (r_op_q)
                        c_op_add, c_op_sub, c_op_and, c_op_or, c_op_addi: r_state <= c_st_wb;
                        c_op_lw, c_op_sw:                                 r_state <= c_st_mem;
                        default:                                          r_state <= c_st_fetch;
                    endcase
                end
                c_st_mem: begin
                    if (mem_ready) begin
                        r_state <= (r_op_q == c_op_lw) ? c_st_wb : c_st_fetch;
                    end
                end
                c_st_wb: begin
                    r_state <= c_st_fetch;
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase
        end
    end

    // Only FETCH/MEM completion and the BEQ branch decision look at live inputs.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_op      = 3'd0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = 1'b0;
        instr_done  = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            c_st_exec: begin
                case (r_op_q)
                    c_op_add, c_op_sub, c_op_and, c_op_or: begin
                        alu_op = {1'b0, r_op_q[1:0]};
                    end
                    c_op_addi, c_op_lw, c_op_sw: begin
                        alu_src_imm = 1'b1;
                    end
                    c_op_beq: begin
                        alu_op     = c_alu_sub;
                        pc_write   = alu_zero;
                        pc_src     = c_pc_rel;
                        instr_done = 1'b1;
                    end
                    c_op_jmp: begin
                        pc_write   = 1'b1;
                        pc_src     = c_pc_abs;
                        instr_done = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            c_st_mem: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (r_op_q == c_op_sw);
                if (mem_ready && (r_op_q == c_op_sw)) begin
                    instr_done = 1'b1;
                end
            end
            c_st_wb: begin
                reg_write  = 1'b1;
                wb_sel     = (r_op_q == c_op_lw);
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_isa16_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isa16_mc_control
//  Brief    : Randomized scoreboard bench for isa16_mc_control.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isa16_mc_control;

    localparam int unsigned RW = 4;

    logic          clk;
    logic          rst_n;
    logic [15:0]   instr;
    logic          alu_zero;
    logic          mem_ready;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0]    pc_src;
    logic [2:0]    alu_op;
    logic          alu_src_imm, reg_write, wb_sel, instr_done, halted, illegal;
    logic [RW-1:0] retired;

    isa16_mc_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  alu_op, alu_src_imm, reg_write, wb_sel, instr_done};

    typedef struct packed {
        logic        rdy;
        logic        z;
        logic [13:0] exp;
    } step_t;

    step_t         plan[$];
    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] model_ret = '0;

    function automatic logic [13:0] pk(input logic mreq, input logic mwe, input logic asel,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic [2:0] aop, input logic imm, input logic rw,
                                       input logic wbs, input logic done);
        return {mreq, mwe, asel, irw, pcw, psrc, aop, imm, rw, wbs, done};
    endfunction

    function automatic step_t mk(input logic r, input logic zz, input logic [13:0] e);
        step_t s;
        s.rdy = r;
        s.z   = zz;
        s.exp = e;
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one instruction, straight from the ISA timing rules.
    function automatic void build(input logic [15:0] ins, input int fw, input int mw, input logic z);
        logic [3:0] op;
        logic       sw;
        op = ins[15:12];
        sw = (op == 4'd6);
        plan.delete();
        for (int k = 0; k < fw; k++)
            plan.push_back(mk(1'b0, rb(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        plan.push_back(mk(1'b1, rb(), pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        plan.push_back(mk(rb(), rb(), 14'd0));
        if (op <= 4'd3) begin
            plan.push_back(mk(rb(), rb(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, {1'b0, op[1:0]}, 1'b0, 1'b0, 1'b0, 1'b0)));
            plan.push_back(mk(rb(), rb(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1)));
        end else if (op <= 4'd6) begin
            plan.push_back(mk(rb(), rb(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
            if (op != 4'd4) begin
                for (int k = 0; k < mw; k++)
                    plan.push_back(mk(1'b0, rb(), pk(1'b1, sw, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
                plan.push_back(mk(1'b1, rb(), pk(1'b1, sw, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, sw)));
            end
            if (!sw)
                plan.push_back(mk(rb(), rb(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1, (op == 4'd5), 1'b1)));
        end else if (op == 4'd7) begin
            plan.push_back(mk(rb(), z, pk(1'b0, 1'b0, 1'b0, 1'b0, z, 2'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1)));
        end else if (op == 4'd8) begin
            plan.push_back(mk(rb(), rb(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1)));
        end
    endfunction

    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic z,
                             input int abort_sel, output int done_cyc);
        int         abort_at;
        bit         aborted;
        logic [3:0] op;
        op = ins[15:12];
        build(ins, fw, mw, z);
        abort_at = (abort_sel >= 0) ? (abort_sel % plan.size()) : -1;
        aborted  = 1'b0;
        done_cyc = 0;
        instr    = ins;
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk);
            mem_ready = plan[i].rdy;
            alu_zero  = plan[i].z;
            if (i == abort_at) rst_n = 1'b0;
            #1;
            checks++;
            if (obs !== plan[i].exp) begin
                errors++;
                $display("FAIL trace ins=%h cycle=%0d got=%b expected=%b", ins, i + 1, obs, plan[i].exp);
            end
            if (obs[0] === 1'b1 && done_cyc == 0) done_cyc = i + 1;
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst_n     = 1'b1;
            mem_ready = 1'b0;
            #1;
            model_ret = '0;
            checks++;
            if (obs !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0) ||
                retired !== model_ret || halted !== 1'b0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL abort ins=%h got=%b ret=%0d h=%b i=%b expected fetch-only, ret=0", ins, obs, retired, halted, illegal);
            end
        end else begin
            if (plan[plan.size() - 1].exp[0]) model_ret = model_ret + 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (retired !== model_ret) begin
                errors++;
                $display("FAIL retired ins=%h got=%0d expected=%0d", ins, retired, model_ret);
            end
            checks++;
            if (halted !== (op >= 4'd9) || illegal !== (op >= 4'd9 && op != 4'd15)) begin
                errors++;
                $display("FAIL stop_flags ins=%h got h=%b i=%b", ins, halted, illegal);
            end
        end
    endtask

    task automatic hold_halted(input int n, input logic exp_ill);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = rb();
            alu_zero  = rb();
            #1;
            checks++;
            if (obs !== 14'd0 || halted !== 1'b1 || illegal !== exp_ill || retired !== model_ret) begin
                errors++;
                $display("FAIL halt_hold cycle=%0d got=%b h=%b i=%b ret=%0d expected 0,1,%b,%0d",
                         i, obs, halted, illegal, retired, exp_ill, model_ret);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = rb();
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        model_ret = '0;
        checks++;
        if (obs !== pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0) ||
            halted !== 1'b0 || illegal !== 1'b0 || retired !== model_ret) begin
            errors++;
            $display("FAIL reset got=%b h=%b i=%b ret=%0d expected mem_req only, flags 0, ret 0", obs, halted, illegal, retired);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add();
        int dc;
        run_instr(16'h0298, 0, 0, 1'b0, -1, dc);
        checks++;
        if (dc != 4) begin errors++; $display("FAIL add_latency got=%0d expected=4", dc); end
    endtask

    task automatic test_lw_wait();
        int dc;
        run_instr(16'h5A43, 0, 2, 1'b0, -1, dc);
        checks++;
        if (dc != 7) begin errors++; $display("FAIL lw_latency got=%0d expected=7", dc); end
    endtask

    task automatic test_beq();
        int dc;
        run_instr(16'h7A5F, 0, 0, 1'b1, -1, dc);
        checks++;
        if (dc != 3) begin errors++; $display("FAIL beq_taken_latency got=%0d expected=3", dc); end
        run_instr(16'h7A5F, 0, 0, 1'b0, -1, dc);
        checks++;
        if (dc != 3) begin errors++; $display("FAIL beq_not_taken_latency got=%0d expected=3", dc); end
    endtask

    task automatic test_illegal();
        int dc;
        run_instr(16'hA123, 1, 0, 1'b0, -1, dc);
        hold_halted(20, 1'b1);
        do_reset();
    endtask

    task automatic test_halt_reset();
        int dc;
        run_instr(16'hF000, 0, 0, 1'b0, -1, dc);
        hold_halted(3, 1'b0);
        do_reset();
    endtask

    task automatic test_wrap();
        int dc;
        for (int k = 1; k <= 16; k++) begin
            run_instr(16'h8000 | 16'($urandom_range(0, 4095)), 0, 0, 1'b0, -1, dc);
            checks++;
            if (retired !== RW'(k % 16)) begin
                errors++;
                $display("FAIL wrap jmp=%0d got=%0d expected=%0d", k, retired, k % 16);
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        int dc;
        // Reset lands on the second MEM wait cycle of a store.
        run_instr(16'h6A43, 0, 3, 1'b0, 4, dc);
        checks++;
        if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL sw_abort got mem_we=%b mem_req=%b expected 0,1", mem_we, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        int         dc;
        logic [3:0] op;
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 99) < 88) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
            run_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1, dc);
            if (halted === 1'b1) begin
                hold_halted(3, illegal);
                do_reset();
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 16'h0000;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_halt_reset();
        test_wrap();
        test_reset_mid_sw();
        do_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
